// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: programmable serial sequence detector with run control,
// saturating match counter and an optional completion target.
// Optional feature macro: SEQ_MATCH_OVERLAP_EN. When it is defined, history
// survives a match, so overlapping occurrences count. When it is undefined,
// the valid-bit count restarts after every match.
module seq_match_ctrl #(
   parameter int PW = 8,
   parameter int CW = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [PW-1:0]           cfg_pattern,
   input  logic [$clog2(PW):0]     cfg_len,
   input  logic [CW-1:0]           cfg_target,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    din_valid,
   input  logic                    din,
   output logic                    busy,
   output logic                    match,
   output logic [CW-1:0]           match_count,
   output logic                    done,
   output logic                    err
);

   localparam int LW = $clog2(PW) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pattern_q, pattern_d;
   logic [LW-1:0]   len_q, len_d;
   logic [CW-1:0]   target_q, target_d;
   // Only PW-1 history bits are stored: the oldest bit falls off on the
   // next shift anyway, and the match compare works on the shifted value.
   logic [PW-2:0]   hist_q, hist_d;
   logic [LW-1:0]   hcnt_q, hcnt_d;
   logic [CW-1:0]   matchCount_q, matchCount_d;
   logic            match_q, match_d;
   logic            err_q, err_d;

   logic [PW-1:0]   histShift;
   logic [PW-1:0]   lenMask;
   logic [LW-1:0]   hcntInc;
   logic [CW-1:0]   countInc;
   logic            lenLegal;
   logic            hitNow;

   // Datapath helpers: shifted history, length mask and the match decision
   always_comb begin
      lenMask = '0;
      for (int i = 0; i < PW; i++) begin
         lenMask[i] = (i < int'(len_q));
      end
      histShift = {hist_q, din};
      hcntInc   = (hcnt_q == LW'(PW)) ? hcnt_q : hcnt_q + 1'b1;
      countInc  = (matchCount_q == '1) ? matchCount_q : matchCount_q + 1'b1;
      lenLegal  = (len_q != '0) && (len_q <= LW'(PW));
      hitNow    = din_valid && (hcntInc >= len_q) &&
                  (((histShift ^ pattern_q) & lenMask) == '0);
   end

   // Next-state logic for run control, config capture and counters
   always_comb begin
      state_d      = state_q;
      pattern_d    = pattern_q;
      len_d        = len_q;
      target_d     = target_q;
      hist_d       = hist_q;
      hcnt_d       = hcnt_q;
      matchCount_d = matchCount_q;
      match_d      = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_we) begin
               pattern_d = cfg_pattern;
               len_d     = cfg_len;
               target_d  = cfg_target;
            end
            if (!stop && start) begin
               if (lenLegal) begin
                  state_d      = RUN;
                  hist_d       = '0;
                  hcnt_d       = '0;
                  matchCount_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (din_valid) begin
               hist_d = histShift[PW-2:0];
               hcnt_d = hcntInc;
               if (hitNow) begin
                  match_d      = 1'b1;
                  matchCount_d = countInc;
`ifndef SEQ_MATCH_OVERLAP_EN
                  hcnt_d       = '0;
`endif
                  if ((target_q != '0) && (countInc == target_q)) begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               if (lenLegal) begin
                  state_d      = RUN;
                  hist_d       = '0;
                  hcnt_d       = '0;
                  matchCount_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset restores the default 101 detector
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pattern_q    <= PW'(3'b101);
         len_q        <= LW'(3);
         target_q     <= '0;
         hist_q       <= '0;
         hcnt_q       <= '0;
         matchCount_q <= '0;
         match_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pattern_q    <= pattern_d;
         len_q        <= len_d;
         target_q     <= target_d;
         hist_q       <= hist_d;
         hcnt_q       <= hcnt_d;
         matchCount_q <= matchCount_d;
         match_q      <= match_d;
         err_q        <= err_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign match       = match_q;
   assign err         = err_q;
   assign match_count = matchCount_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl (PW=8, CW=8). Expected values are
// hand-derived; the overlap-dependent ones follow SEQ_MATCH_OVERLAP_EN.
module tb_seq_match_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic [7:0] cfg_target = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       din_valid = 1'b0;
   logic       din = 1'b0;
   logic       busy, match, done, err;
   logic [7:0] match_count;

   int errorCount = 0;
   int checkCount = 0;

   seq_match_ctrl #(.PW(8), .CW(8)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .stop(stop),
      .din_valid(din_valid), .din(din), .busy(busy), .match(match),
      .match_count(match_count), .done(done), .err(err)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic sp,
                                input logic dv, input logic d);
      start = st; stop = sp; din_valid = dv; din = d;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 1'b0;
   endtask

   task automatic sendBit(input logic b);
      applyStimulus(1'b0, 1'b0, 1'b1, b);
   endtask

   task automatic writeCfg(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t);
      cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_we = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      logic [4:0] expMatch1;
      logic [6:0] stream2;
      logic       sawDone;
      logic [7:0] expCount1;
`ifdef SEQ_MATCH_OVERLAP_EN
      expMatch1 = 5'b10100;
      expCount1 = 8'd2;
`else
      expMatch1 = 5'b00100;
      expCount1 = 8'd1;
`endif
      stream2 = 7'b1101101;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_match", match, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_count", match_count, 0);

      // Default 101 detector on 1,0,1,0,1
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         sendBit(i[0] ? 1'b0 : 1'b1);
         checkOutput($sformatf("t1_match%0d", i + 1), match, expMatch1[i]);
      end
      checkOutput("t1_count", match_count, expCount1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_stop_busy", busy, 0);
      checkOutput("t1_hold_count", match_count, expCount1);

      // Target 2 on 1,0,1,1,0,1 then an ignored seventh bit
      writeCfg(8'b101, 4'd3, 8'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         sendBit(stream2[i]);
         if (i == 2) begin
            checkOutput("t2_match3", match, 1);
            checkOutput("t2_done3", done, 0);
         end
      end
      checkOutput("t2_match6", match, 1);
      checkOutput("t2_done6", done, 1);
      checkOutput("t2_busy6", busy, 0);
      checkOutput("t2_count6", match_count, 2);
      sendBit(stream2[6]);
      checkOutput("t2_match7", match, 0);
      checkOutput("t2_count7", match_count, 2);
      checkOutput("t2_done7", done, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_restart_busy", busy, 1);
      checkOutput("t2_restart_count", match_count, 0);
      checkOutput("t2_restart_done", done, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_idle_busy", busy, 0);

      // Illegal length on start
      writeCfg(8'b101, 4'd0, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_err", err, 1);
      checkOutput("t3_busy", busy, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_err_clear", err, 0);
      writeCfg(8'b101, 4'd9, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_err_long", err, 1);
      checkOutput("t3_busy_long", busy, 0);

      // Stop discards a same-cycle bit; cfg_we ignored while running
      writeCfg(8'b1101, 4'd4, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("t4_stop_match", match, 0);
      checkOutput("t4_stop_busy", busy, 0);
      checkOutput("t4_stop_count", match_count, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      writeCfg(8'b0011, 4'd4, 8'd1);
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      checkOutput("t4_cfg_kept_match", match, 1);
      checkOutput("t4_cfg_kept_count", match_count, 1);
      checkOutput("t4_cfg_kept_busy", busy, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Reset mid-run restores defaults
      writeCfg(8'b1, 4'd1, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      checkOutput("t5_count3", match_count, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_count", match_count, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      sendBit(1'b1);
      checkOutput("t5_def_match1", match, 0);
      sendBit(1'b0);
      sendBit(1'b1);
      checkOutput("t5_def_match3", match, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Free-run saturation at 255
      writeCfg(8'b1, 4'd1, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      sawDone = 1'b0;
      for (int i = 0; i < 300; i++) begin
         sendBit(1'b1);
         if (done) sawDone = 1'b1;
         if (i == 254) checkOutput("t6_count255", match_count, 255);
      end
      checkOutput("t6_sat_count", match_count, 255);
      checkOutput("t6_sat_match", match, 1);
      checkOutput("t6_never_done", sawDone, 0);
      checkOutput("t6_busy", busy, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_stop_beats_start", busy, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
